// File: rtl/comperator_pkg.sv
// Shared definitions for the comparator-stream consumers: FSM state encoding
// and the counter-width helper.
package comperator_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Bits needed to hold the value n-1; call with WIN+1 to size a 0..WIN counter.
    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/comperator_window_stats.sv
// Accumulates WIN comparator samples into gt/eq/lt tallies and a window max,
// then holds the result on a valid/ready output until it is consumed.
module comperator_window_stats
    import comperator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int WIN   = 16,
    parameter int CNT_W = clog2_f(WIN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    input  logic             D,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [WIDTH-1:0] max_val,
    output logic             err
);

    state_t           state;
    logic [CNT_W-1:0] sample_cnt;
    logic [WIDTH-1:0] pick;
    logic             accept;
    logic             last_sample;

    // Handshake flags decode the state bit only, so no input reaches them combinationally.
    assign in_ready    = (state == ST_ACCUM);
    assign out_valid   = (state == ST_HOLD);
    assign accept      = in_valid & in_ready;
    assign pick        = C ? A : B;
    assign last_sample = (sample_cnt == CNT_W'(WIN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_ACCUM;
            sample_cnt <= '0;
            gt_cnt     <= '0;
            eq_cnt     <= '0;
            lt_cnt     <= '0;
            max_val    <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (accept) begin
                        // D wins over C; the C&D pair is illegal and flags the window.
                        if (D) begin
                            eq_cnt <= eq_cnt + CNT_W'(1);
                            if (C) err <= 1'b1;
                        end else if (C) begin
                            gt_cnt <= gt_cnt + CNT_W'(1);
                        end else begin
                            lt_cnt <= lt_cnt + CNT_W'(1);
                        end
                        if (pick > max_val) max_val <= pick;
                        sample_cnt <= sample_cnt + CNT_W'(1);
                        if (last_sample) state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state      <= ST_ACCUM;
                        sample_cnt <= '0;
                        gt_cnt     <= '0;
                        eq_cnt     <= '0;
                        lt_cnt     <= '0;
                        max_val    <= '0;
                        err        <= 1'b0;
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_comperator_window_stats.sv
// Directed bench for comperator_window_stats with WIN=4, WIDTH=8.
module tb_comperator_window_stats;

    localparam int WIDTH = 8;
    localparam int WIN   = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C;
    logic             D;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [WIDTH-1:0] max_val;
    logic             err;

    int n_cmp;
    int n_bad;

    comperator_window_stats #(.WIDTH(WIDTH), .WIN(WIN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .C(C), .D(D),
        .out_valid(out_valid), .out_ready(out_ready),
        .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt),
        .max_val(max_val), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input int gt, input int eq, input int lt,
                           input int mx, input int e);
        chk({tag, "_gt"},  32'(gt_cnt),  32'(gt));
        chk({tag, "_eq"},  32'(eq_cnt),  32'(eq));
        chk({tag, "_lt"},  32'(lt_cnt),  32'(lt));
        chk({tag, "_max"}, 32'(max_val), 32'(mx));
        chk({tag, "_err"}, 32'(err),     32'(e));
    endtask

    // Present one sample for one clock; inputs change 1 time unit after the edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c, input logic d);
        in_valid = 1'b1; A = a; B = b; C = c; D = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // One cycle with in_valid low but garbage on the data lines.
    task automatic idle_garbage();
        in_valid = 1'b0; A = 8'hFF; B = 8'hFF; C = 1'b1; D = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; C = 1'b0; D = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk_res("rst", 0, 0, 0, 0, 0);

        // Basic window
        send(8'd1, 8'd0, 1'b1, 1'b0);
        send(8'd2, 8'd2, 1'b0, 1'b1);
        send(8'd6, 8'd2, 1'b1, 1'b0);
        chk("w1_not_yet", 32'(out_valid), 32'd0);
        send(8'd5, 8'd9, 1'b0, 1'b0);
        chk("w1_out_valid", 32'(out_valid), 32'd1);
        chk("w1_in_ready", 32'(in_ready), 32'd0);
        chk_res("w1", 2, 1, 1, 9, 0);

        // Backpressure: result frozen, offered samples not consumed
        in_valid = 1'b1; A = 8'hEE; B = 8'h01; C = 1'b1; D = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk_res("hold", 2, 1, 1, 9, 0);
        end
        in_valid = 1'b0;
        consume();
        chk("rel_out_valid", 32'(out_valid), 32'd0);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk_res("rel", 0, 0, 0, 0, 0);

        // Illegal flag pair counts as eq and sets err
        send(8'hAA, 8'hAA, 1'b1, 1'b1);
        send(8'd1, 8'd2, 1'b0, 1'b0);
        send(8'd3, 8'd1, 1'b1, 1'b0);
        send(8'd4, 8'd4, 1'b0, 1'b1);
        chk("werr_out_valid", 32'(out_valid), 32'd1);
        chk_res("werr", 1, 2, 1, 8'hAA, 1);
        consume();

        // Legal window after an err window; high-value max boundary
        send(8'hFD, 8'h82, 1'b1, 1'b0);
        send(8'hC0, 8'hFF, 1'b0, 1'b0);
        send(8'hFE, 8'hFF, 1'b0, 1'b0);
        send(8'h00, 8'h00, 1'b0, 1'b1);
        chk("wmax_out_valid", 32'(out_valid), 32'd1);
        chk_res("wmax", 1, 1, 2, 8'hFF, 0);
        consume();

        // Reset mid-window discards the partial samples
        send(8'd9, 8'd1, 1'b1, 1'b0);
        send(8'd9, 8'd1, 1'b1, 1'b0);
        send(8'd9, 8'd1, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_res("mrst", 0, 0, 0, 0, 0);
        send(8'd1, 8'd2, 1'b0, 1'b0);
        send(8'd1, 8'd2, 1'b0, 1'b0);
        send(8'd1, 8'd2, 1'b0, 1'b0);
        chk("mrst_not_yet", 32'(out_valid), 32'd0);
        send(8'd1, 8'd2, 1'b0, 1'b0);
        chk("mrst_out_valid", 32'(out_valid), 32'd1);
        chk_res("mrst_w", 0, 0, 4, 2, 0);

        // Reset during HOLD drops the pending result
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("hrst_out_valid", 32'(out_valid), 32'd0);
        chk("hrst_in_ready", 32'(in_ready), 32'd1);
        chk_res("hrst", 0, 0, 0, 0, 0);

        // Gapped valid: only handshaked samples count
        send(8'd3, 8'd7, 1'b0, 1'b0);
        idle_garbage();
        send(8'd8, 8'd1, 1'b1, 1'b0);
        idle_garbage();
        send(8'd5, 8'd5, 1'b0, 1'b1);
        idle_garbage();
        chk("gap_not_yet", 32'(out_valid), 32'd0);
        send(8'd2, 8'd6, 1'b0, 1'b0);
        chk("gap_out_valid", 32'(out_valid), 32'd1);
        chk_res("gap", 1, 1, 2, 8, 0);
        in_valid = 1'b1; A = 8'hF0; B = 8'h00; C = 1'b1; D = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("gap_hold_valid", 32'(out_valid), 32'd1);
        chk_res("gap_hold", 1, 1, 2, 8, 0);
        in_valid = 1'b0;
        consume();
        chk_res("gap_rel", 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
